exe_stage: RTL and testbench

Execute stage of the 5-stage pipeline. It sits between the ID2EXE and EXE2MEM pipeline registers and consumes the registered ID/EXE fields directly. It resolves RAW hazards by forwarding from the MEM and WB stages, evaluates single-cycle ALU ops combinationally, and runs MUL/DIV on an iterative multi-cycle unit. While that unit is busy it stalls the front end and sends bubbles downstream.

---
 rtl/exe_stage_pkg.sv | 55 +++++
 rtl/exe_stage_forwarding_unit.sv | 28 ++
 rtl/exe_stage.sv | 198 +++++++++++++++++++
 tb/tb_exe_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, EXE command encodings, MUL/DIV FSM states and forwarding selects
// for the execute stage.
package exe_stage_pkg;

    localparam int WORD_LEN          = 16;
    localparam int REG_FILE_ADDR_LEN = 4;
    localparam int EXE_CMD_LEN       = 4;
    localparam int SHAMT_W           = $clog2(WORD_LEN);
    localparam int CNT_W             = $clog2(WORD_LEN);

    typedef enum logic [EXE_CMD_LEN-1:0] {
        EXE_ADD   = 4'd0,
        EXE_SUB   = 4'd1,
        EXE_AND   = 4'd2,
        EXE_OR    = 4'd3,
        EXE_XOR   = 4'd4,
        EXE_SLL   = 4'd5,
        EXE_SRL   = 4'd6,
        EXE_MUL   = 4'd7,
        EXE_DIV   = 4'd8,
        EXE_NO_OP = 4'd15
    } exe_cmd_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    typedef enum logic [1:0] {
        FWD_ID  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // MEM is checked first so the younger result wins; R0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_FILE_ADDR_LEN-1:0] src,
        input logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
        input logic                         mem_we,
        input logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
        input logic                         wb_we
    );
        fwd_sel_t sel;
        sel = FWD_ID;
        if (src != '0) begin
            if (mem_we && (mem_dest == src))
                sel = FWD_MEM;
            else if (wb_we && (wb_dest == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/exe_stage_forwarding_unit.sv
// Combinational RAW-hazard detection producing forwarding selects for the
// A, B and store-data operands of the execute stage.
module forwarding_unit
    import exe_stage_pkg::*;
(
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic                         is_imm,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic                         mem_WB_EN,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic                         wb_WB_EN,
    output fwd_sel_t                     sel_a,
    output fwd_sel_t                     sel_b,
    output fwd_sel_t                     sel_s
);

    fwd_sel_t sel_src2;

    always_comb begin
        sel_a    = fwd_pick(src1, mem_dest, mem_WB_EN, wb_dest, wb_WB_EN);
        sel_src2 = fwd_pick(src2, mem_dest, mem_WB_EN, wb_dest, wb_WB_EN);
        // Store data still comes from src2 when val2 carries the immediate.
        sel_s    = sel_src2;
        sel_b    = is_imm ? FWD_ID : sel_src2;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, single-cycle ALU and an iterative MUL/DIV unit that stalls
// the front end. The iterative divider is built only when EXE_DIV_EN is defined.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EXE_CMD_LEN-1:0]       EXE_CMD,
    input  logic [WORD_LEN-1:0]          val1,
    input  logic [WORD_LEN-1:0]          val2,
    input  logic [WORD_LEN-1:0]          ST_value,
    input  logic                         is_imm,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    input  logic                         WB_EN_in,
    input  logic                         MEM_R_EN_in,
    input  logic                         MEM_W_EN_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic                         mem_WB_EN,
    input  logic                         wb_WB_EN,
    input  logic [WORD_LEN-1:0]          mem_result,
    input  logic [WORD_LEN-1:0]          wb_result,
    output logic [WORD_LEN-1:0]          ALU_result,
    output logic [WORD_LEN-1:0]          ST_value_out,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
    output logic                         WB_EN,
    output logic                         MEM_R_EN,
    output logic                         MEM_W_EN,
    output logic                         stall_exe,
    output logic                         busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

    fwd_sel_t            sel_a, sel_b, sel_s;
    logic [WORD_LEN-1:0] op_a, op_b, op_s;

    md_state_t           state;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_LEN-1:0] acc;
    logic [WORD_LEN-1:0] opnd_a;
    logic [WORD_LEN-1:0] opnd_b;
    logic [WORD_LEN-1:0] md_result;

    logic is_mul_cmd;
    logic is_muldiv_cmd;

    forwarding_unit u_fwd (
        .src1      (src1),
        .src2      (src2),
        .is_imm    (is_imm),
        .mem_dest  (mem_dest),
        .mem_WB_EN (mem_WB_EN),
        .wb_dest   (wb_dest),
        .wb_WB_EN  (wb_WB_EN),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_s     (sel_s)
    );

    always_comb begin
        case (sel_a)
            FWD_MEM: op_a = mem_result;
            FWD_WB:  op_a = wb_result;
            default: op_a = val1;
        endcase
        case (sel_b)
            FWD_MEM: op_b = mem_result;
            FWD_WB:  op_b = wb_result;
            default: op_b = val2;
        endcase
        case (sel_s)
            FWD_MEM: op_s = mem_result;
            FWD_WB:  op_s = wb_result;
            default: op_s = ST_value;
        endcase
    end

    assign is_mul_cmd = (EXE_CMD == EXE_MUL);

`ifdef EXE_DIV_EN
    logic                is_div_cmd;
    logic                op_div;
    logic [WORD_LEN:0]   div_shift;
    logic [WORD_LEN:0]   div_diff;
    logic                div_borrow;
    logic [WORD_LEN-1:0] div_rem_next;
    logic [WORD_LEN-1:0] div_quo_next;

    assign is_div_cmd    = (EXE_CMD == EXE_DIV);
    assign is_muldiv_cmd = is_mul_cmd | is_div_cmd;

    // Restoring step: acc is the partial remainder, opnd_a shifts the dividend out
    // at the top and collects quotient bits at the bottom, opnd_b holds the divisor.
    assign div_shift    = {acc, opnd_a[WORD_LEN-1]};
    assign div_diff     = div_shift - {1'b0, opnd_b};
    assign div_borrow   = div_diff[WORD_LEN];
    assign div_rem_next = div_borrow ? {acc[WORD_LEN-2:0], opnd_a[WORD_LEN-1]}
                                     : div_diff[WORD_LEN-1:0];
    assign div_quo_next = {opnd_a[WORD_LEN-2:0], ~div_borrow};
    assign md_result    = op_div ? opnd_a : acc;
`else
    assign is_muldiv_cmd = is_mul_cmd;
    assign md_result     = acc;
`endif

    // Operands are captured at issue since MEM/WB drain while the front end is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd_a <= '0;
            opnd_b <= '0;
`ifdef EXE_DIV_EN
            op_div <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: begin
                    if (is_muldiv_cmd) begin
                        cnt    <= '0;
                        acc    <= '0;
                        opnd_a <= op_a;
                        opnd_b <= op_b;
                        state  <= MD_BUSY;
`ifdef EXE_DIV_EN
                        op_div <= is_div_cmd;
                        if (is_div_cmd && (op_b == '0)) begin
                            opnd_a <= '1;
                            state  <= MD_DONE;
                        end
`endif
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt + 1'b1;
`ifdef EXE_DIV_EN
                    if (op_div) begin
                        acc    <= div_rem_next;
                        opnd_a <= div_quo_next;
                    end else begin
                        if (opnd_b[0])
                            acc <= acc + opnd_a;
                        opnd_a <= opnd_a << 1;
                        opnd_b <= opnd_b >> 1;
                    end
`else
                    if (opnd_b[0])
                        acc <= acc + opnd_a;
                    opnd_a <= opnd_a << 1;
                    opnd_b <= opnd_b >> 1;
`endif
                    if (cnt == CNT_LAST)
                        state <= MD_DONE;
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign stall_exe = is_muldiv_cmd && (state != MD_DONE);
    assign busy      = (state != MD_IDLE);

    always_comb begin
        case (EXE_CMD)
            EXE_ADD:   ALU_result = op_a + op_b;
            EXE_SUB:   ALU_result = op_a - op_b;
            EXE_AND:   ALU_result = op_a & op_b;
            EXE_OR:    ALU_result = op_a | op_b;
            EXE_XOR:   ALU_result = op_a ^ op_b;
            EXE_SLL:   ALU_result = op_a << op_b[SHAMT_W-1:0];
            EXE_SRL:   ALU_result = op_a >> op_b[SHAMT_W-1:0];
            EXE_MUL:   ALU_result = (state == MD_DONE) ? md_result : '0;
`ifdef EXE_DIV_EN
            EXE_DIV:   ALU_result = (state == MD_DONE) ? md_result : '0;
`else
            EXE_DIV:   ALU_result = '0;
`endif
            default:   ALU_result = '0;
        endcase
    end

    // Bubble downstream while the iterative unit owns the stage.
    assign WB_EN        = WB_EN_in    & ~stall_exe;
    assign MEM_R_EN     = MEM_R_EN_in & ~stall_exe;
    assign MEM_W_EN     = MEM_W_EN_in & ~stall_exe;
    assign dest_out     = dest_in;
    assign ST_value_out = op_s;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU ops, forwarding priority, MUL/DIV
// stall timing, reset mid-operation and the EXE_DIV_EN build option.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic                         clk;
    logic                         rst;
    logic [EXE_CMD_LEN-1:0]       exe_cmd;
    logic [WORD_LEN-1:0]          val1, val2, st_value;
    logic                         is_imm;
    logic [REG_FILE_ADDR_LEN-1:0] src1, src2, dest_in;
    logic                         wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [REG_FILE_ADDR_LEN-1:0] mem_dest, wb_dest;
    logic                         mem_wb_en, wb_wb_en;
    logic [WORD_LEN-1:0]          mem_result, wb_result;
    logic [WORD_LEN-1:0]          alu_result, st_value_out;
    logic [REG_FILE_ADDR_LEN-1:0] dest_out;
    logic                         wb_en, mem_r_en, mem_w_en, stall_exe, busy;

    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_CMD      (exe_cmd),
        .val1         (val1),
        .val2         (val2),
        .ST_value     (st_value),
        .is_imm       (is_imm),
        .src1         (src1),
        .src2         (src2),
        .dest_in      (dest_in),
        .WB_EN_in     (wb_en_in),
        .MEM_R_EN_in  (mem_r_en_in),
        .MEM_W_EN_in  (mem_w_en_in),
        .mem_dest     (mem_dest),
        .wb_dest      (wb_dest),
        .mem_WB_EN    (mem_wb_en),
        .wb_WB_EN     (wb_wb_en),
        .mem_result   (mem_result),
        .wb_result    (wb_result),
        .ALU_result   (alu_result),
        .ST_value_out (st_value_out),
        .dest_out     (dest_out),
        .WB_EN        (wb_en),
        .MEM_R_EN     (mem_r_en),
        .MEM_W_EN     (mem_w_en),
        .stall_exe    (stall_exe),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge and are sampled 1 ns later.
    task automatic applyStimulus(input exe_cmd_t cmd, input logic [WORD_LEN-1:0] a,
                                 input logic [WORD_LEN-1:0] b,
                                 input logic [REG_FILE_ADDR_LEN-1:0] s1,
                                 input logic [REG_FILE_ADDR_LEN-1:0] s2);
        @(negedge clk);
        exe_cmd = cmd;
        val1    = a;
        val2    = b;
        src1    = s1;
        src2    = s2;
        #1;
    endtask

    task automatic runMulDiv(input string tag, input exe_cmd_t cmd,
                             input logic [WORD_LEN-1:0] a, input logic [WORD_LEN-1:0] b,
                             input logic [WORD_LEN-1:0] exp_res, input int exp_stalls);
        int stalls;
        stalls = 0;
        applyStimulus(cmd, a, b, 4'd0, 4'd0);
        while (stall_exe === 1'b1 && stalls < 40) begin
            stalls++;
            checkOutput({tag, " wb_en_stall"}, {31'd0, wb_en}, 32'd0);
            @(negedge clk);
            #1;
        end
        checkOutput({tag, " stall_cycles"}, stalls, exp_stalls);
        checkOutput({tag, " result"}, {16'd0, alu_result}, {16'd0, exp_res});
        checkOutput({tag, " wb_en_done"}, {31'd0, wb_en}, 32'd1);
        checkOutput({tag, " busy_done"}, {31'd0, busy}, 32'd1);
        applyStimulus(EXE_NO_OP, 16'd0, 16'd0, 4'd0, 4'd0);
        checkOutput({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        exe_cmd = EXE_NO_OP;
        val1 = 16'd5; val2 = 16'd0; st_value = 16'd0; is_imm = 1'b0;
        src1 = 4'd0; src2 = 4'd0; dest_in = 4'd9;
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        mem_dest = 4'd0; wb_dest = 4'd0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
        mem_result = 16'd0; wb_result = 16'd0;
        #12;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset stall", {31'd0, stall_exe}, 32'd0);
        checkOutput("reset no_op", {16'd0, alu_result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(EXE_ADD, 16'd5, 16'd7, 4'd1, 4'd2);
        checkOutput("add", {16'd0, alu_result}, 32'd12);
        checkOutput("add stall", {31'd0, stall_exe}, 32'd0);
        checkOutput("add wb_en", {31'd0, wb_en}, 32'd1);
        checkOutput("add mem_r_en", {31'd0, mem_r_en}, 32'd1);
        checkOutput("add dest", {28'd0, dest_out}, 32'd9);

        applyStimulus(EXE_SUB, 16'd5, 16'd7, 4'd1, 4'd2);
        checkOutput("sub wrap", {16'd0, alu_result}, 32'h0000FFFE);
        applyStimulus(EXE_AND, 16'hF0F0, 16'h0FF0, 4'd1, 4'd2);
        checkOutput("and", {16'd0, alu_result}, 32'h000000F0);
        applyStimulus(EXE_OR, 16'hF0F0, 16'h0FF0, 4'd1, 4'd2);
        checkOutput("or", {16'd0, alu_result}, 32'h0000FFF0);
        applyStimulus(EXE_XOR, 16'hF0F0, 16'h0FF0, 4'd1, 4'd2);
        checkOutput("xor", {16'd0, alu_result}, 32'h0000FF00);
        applyStimulus(EXE_SLL, 16'h0001, 16'h0013, 4'd1, 4'd2);
        checkOutput("sll low4", {16'd0, alu_result}, 32'h00000008);
        applyStimulus(EXE_SRL, 16'h8000, 16'h000F, 4'd1, 4'd2);
        checkOutput("srl max", {16'd0, alu_result}, 32'h00000001);
        applyStimulus(EXE_NO_OP, 16'h1234, 16'h0001, 4'd1, 4'd2);
        checkOutput("no_op", {16'd0, alu_result}, 32'd0);

        mem_dest = 4'd3; wb_dest = 4'd3; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
        mem_result = 16'h00AA; wb_result = 16'h0055; st_value = 16'h0777;
        applyStimulus(EXE_ADD, 16'h1000, 16'h0001, 4'd3, 4'd1);
        checkOutput("fwd mem priority", {16'd0, alu_result}, 32'h000000AB);
        applyStimulus(EXE_ADD, 16'h1000, 16'h0001, 4'd0, 4'd1);
        checkOutput("fwd r0 blocked", {16'd0, alu_result}, 32'h00001001);
        mem_wb_en = 1'b0;
        applyStimulus(EXE_ADD, 16'h1000, 16'h0001, 4'd3, 4'd1);
        checkOutput("fwd wb", {16'd0, alu_result}, 32'h00000056);
        mem_wb_en = 1'b1;
        applyStimulus(EXE_ADD, 16'h0002, 16'h0100, 4'd1, 4'd3);
        checkOutput("fwd b", {16'd0, alu_result}, 32'h000000AC);
        checkOutput("fwd store", {16'd0, st_value_out}, 32'h000000AA);
        is_imm = 1'b1;
        applyStimulus(EXE_ADD, 16'h0002, 16'h0100, 4'd1, 4'd3);
        checkOutput("imm no fwd", {16'd0, alu_result}, 32'h00000102);
        checkOutput("imm store fwd", {16'd0, st_value_out}, 32'h000000AA);
        is_imm = 1'b0;
        mem_wb_en = 1'b0; wb_wb_en = 1'b0;
        applyStimulus(EXE_ADD, 16'h0002, 16'h0100, 4'd1, 4'd3);
        checkOutput("store no fwd", {16'd0, st_value_out}, 32'h00000777);

        runMulDiv("mul 300x300", EXE_MUL, 16'd300, 16'd300, 16'h5F90, 17);
        runMulDiv("mul ffff x ffff", EXE_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 17);

`ifdef EXE_DIV_EN
        runMulDiv("div 1000/7", EXE_DIV, 16'd1000, 16'd7, 16'd142, 17);
        runMulDiv("div ffff/1", EXE_DIV, 16'hFFFF, 16'd1, 16'hFFFF, 17);
        runMulDiv("div by zero", EXE_DIV, 16'd1000, 16'd0, 16'hFFFF, 1);
`else
        applyStimulus(EXE_DIV, 16'd1000, 16'd7, 4'd0, 4'd0);
        checkOutput("nodiv result", {16'd0, alu_result}, 32'd0);
        checkOutput("nodiv stall", {31'd0, stall_exe}, 32'd0);
        checkOutput("nodiv wb_en", {31'd0, wb_en}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("nodiv busy", {31'd0, busy}, 32'd0);
`endif

        applyStimulus(EXE_MUL, 16'd300, 16'd300, 4'd0, 4'd0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        exe_cmd = EXE_NO_OP;
        #1;
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid reset stall", {31'd0, stall_exe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        runMulDiv("mul after reset", EXE_MUL, 16'd123, 16'd45, 16'h159F, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
